// File: rtl/rate_enable_gen.sv
// Rate-select enable generator: turns start/stop/step edges into a RUNNING state
// and a periodic single-cycle count-enable pulse for a downstream counter.
module rate_enable_gen #(
   parameter int CLK_HZ = 50000000,
   parameter int CNT_W  = 28
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic [1:0] speed,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   output logic       enable,
   output logic       running
);

   typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

   localparam logic [CNT_W-1:0] ReloadOne  = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] ReloadTwo  = CNT_W'(2 * CLK_HZ - 1);
   localparam logic [CNT_W-1:0] ReloadFour = CNT_W'(4 * CLK_HZ - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] reload;
   logic             enable_q, enable_d;
   logic             startPrev_q, stopPrev_q, stepPrev_q;
   logic [1:0]       speedPrev_q;
   logic             startEdge, stopEdge, stepEdge, speedChange;

   assign startEdge   = start & ~startPrev_q;
   assign stopEdge    = stop & ~stopPrev_q;
   assign stepEdge    = step & ~stepPrev_q;
   assign speedChange = (speed != speedPrev_q);

   always_comb begin
      reload = '0;
      case (speed)
         2'b00:   reload = '0;
         2'b01:   reload = ReloadOne;
         2'b10:   reload = ReloadTwo;
         default: reload = ReloadFour;
      endcase
   end

   // Stop beats start, start beats step; a speed change restarts the period.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      enable_d = 1'b0;
      case (state_q)
         STOPPED: begin
            if (startEdge && !stopEdge) begin
               state_d = RUNNING;
               count_d = reload;
            end else if (stepEdge && !startEdge) begin
               enable_d = 1'b1;
            end
         end
         RUNNING: begin
            if (stopEdge) begin
               state_d = STOPPED;
            end else if (speedChange) begin
               count_d = reload;
            end else if (count_q == '0) begin
               enable_d = 1'b1;
               count_d  = reload;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: state_d = STOPPED;
      endcase
   end

   // Edge history resets high so a level held through reset is not an edge.
   always_ff @(posedge clock) begin
      if (resetb) begin
         state_q     <= STOPPED;
         count_q     <= '0;
         enable_q    <= 1'b0;
         startPrev_q <= 1'b1;
         stopPrev_q  <= 1'b1;
         stepPrev_q  <= 1'b1;
         speedPrev_q <= speed;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         enable_q    <= enable_d;
         startPrev_q <= start;
         stopPrev_q  <= stop;
         stepPrev_q  <= step;
         speedPrev_q <= speed;
      end
   end

   assign enable  = enable_q;
   assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_rate_enable_gen.sv
// Self-checking bench for rate_enable_gen: directed scenarios with literal
// expectations plus randomized traffic compared against a period-counting model.
module tb_rate_enable_gen;

   localparam int CLK_HZ = 4;
   localparam int CNT_W  = 5;

   logic       clock = 1'b0;
   logic       resetb;
   logic [1:0] speed;
   logic       start, stop, step;
   logic       enable, running;

   int checks = 0;
   int passes = 0;
   int cycle  = 0;

   always #5 clock = ~clock;

   rate_enable_gen #(
      .CLK_HZ(CLK_HZ),
      .CNT_W (CNT_W)
   ) dut (
      .clock  (clock),
      .resetb (resetb),
      .speed  (speed),
      .start  (start),
      .stop   (stop),
      .step   (step),
      .enable (enable),
      .running(running)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
   endtask

   function automatic int periodOf(input logic [1:0] s);
      case (s)
         2'b00:   return 1;
         2'b01:   return CLK_HZ;
         2'b10:   return 2 * CLK_HZ;
         default: return 4 * CLK_HZ;
      endcase
   endfunction

   // Reference model: counts cycles since the period began and fires when a full period has elapsed.
   bit         modelValid = 1'b0;
   bit         mRun, mEn;
   int         mSince, mN;
   bit         pStart, pStop, pStep;
   logic [1:0] pSpeed;
   bit         eStart, eStop, eStep, eSpeed;

   always @(posedge clock) begin
      cycle++;
      if (resetb) begin
         mRun = 0; mEn = 0; mSince = 0; mN = 1;
         pStart = 1; pStop = 1; pStep = 1; pSpeed = speed;
         modelValid = 1;
      end else begin
         eStart = start && !pStart;
         eStop  = stop && !pStop;
         eStep  = step && !pStep;
         eSpeed = (speed != pSpeed);
         mEn = 0;
         if (!mRun) begin
            if (eStart && !eStop) begin
               mRun = 1; mSince = 0; mN = periodOf(speed);
            end else if (eStep && !eStart) begin
               mEn = 1;
            end
         end else begin
            if (eStop) mRun = 0;
            else if (eSpeed) begin
               mN = periodOf(speed); mSince = 0;
            end else begin
               mSince++;
               if (mSince >= mN) begin
                  mEn = 1; mSince = 0;
               end
            end
         end
         pStart = start; pStop = stop; pStep = step; pSpeed = speed;
      end
   end

   // Every cycle after the first reset, the DUT must match the model.
   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("model_enable", 32'(enable), 32'(mEn));
         checkOutput("model_running", 32'(running), 32'(mRun));
      end
   end

   task automatic applyStimulus(input logic rst, input logic st, input logic sp,
                                input logic stp, input logic [1:0] spd);
      @(negedge clock);
      resetb = rst; start = st; stop = sp; step = stp; speed = spd;
   endtask

   task automatic pulseStop();
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      @(negedge clock);
   endtask

   logic [31:0] mask;
   int          cnt;

   initial begin
      resetb = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; speed = 2'b01;
      repeat (2) @(negedge clock);
      resetb = 1'b0;
      @(negedge clock);
      checkOutput("reset_enable", 32'(enable), 32'd0);
      checkOutput("reset_running", 32'(running), 32'd0);

      // Test 1: speed 01, pulses every 4 cycles starting 4 cycles after the start edge.
      start = 1'b1;
      mask = '0;
      for (int j = 0; j <= 20; j++) begin
         @(negedge clock);
         if (j == 0) begin
            start = 1'b0;
            checkOutput("t1_running", 32'(running), 32'd1);
         end
         if (enable) mask[j] = 1'b1;
      end
      checkOutput("t1_pulse_mask", mask, 32'h0011_1110);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      checkOutput("t1_stopped", 32'(running), 32'd0);
      @(negedge clock);

      // Test 2: speed 11 gives one pulse per 16 cycles, then a mid-period switch to 00.
      speed = 2'b11;
      start = 1'b1;
      cnt = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clock);
         if (j == 0) start = 1'b0;
         if (enable) cnt++;
      end
      checkOutput("t2_slow_pulses", 32'(cnt), 32'd2);
      speed = 2'b00;
      @(negedge clock);
      checkOutput("t2_change_edge", 32'(enable), 32'd0);
      cnt = 0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clock);
         if (enable) cnt++;
      end
      checkOutput("t2_continuous", 32'(cnt), 32'd5);
      pulseStop();

      // Test 3: three step pulses while stopped, then a step while running is ignored.
      speed = 2'b01;
      cnt = 0;
      for (int j = 0; j < 15; j++) begin
         step = (j % 5 == 0);
         @(negedge clock);
         if (enable) cnt++;
      end
      step = 1'b0;
      checkOutput("t3_step_pulses", 32'(cnt), 32'd3);
      start = 1'b1;
      cnt = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clock);
         if (j == 0) start = 1'b0;
         if (j == 4) step = 1'b1;
         if (j == 5) step = 1'b0;
         if (enable) cnt++;
      end
      checkOutput("t3_run_step", 32'(cnt), 32'd2);
      pulseStop();

      // Test 4: simultaneous start and stop edges leave the block stopped.
      start = 1'b1; stop = 1'b1;
      cnt = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clock);
         if (j == 0) begin
            start = 1'b0; stop = 1'b0;
         end
         if (running || enable) cnt++;
      end
      checkOutput("t4_start_stop", 32'(cnt), 32'd0);

      // Test 5: start held high through reset must not start the block.
      start = 1'b1; resetb = 1'b1;
      repeat (2) @(negedge clock);
      resetb = 1'b0;
      cnt = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clock);
         if (running) cnt++;
      end
      checkOutput("t5_held_start", 32'(cnt), 32'd0);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("t5_restart", 32'(running), 32'd1);
      pulseStop();

      // Test 6: reset while count is 2 abandons the period for good.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      resetb = 1'b1;
      @(negedge clock);
      resetb = 1'b0;
      checkOutput("t6_reset_enable", 32'(enable), 32'd0);
      checkOutput("t6_reset_running", 32'(running), 32'd0);
      cnt = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clock);
         if (enable || running) cnt++;
      end
      checkOutput("t6_no_pulse", 32'(cnt), 32'd0);

      // Randomized traffic checked only by the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : speed);
      end
      resetb = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      @(negedge clock);
      @(negedge clock);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
